// File: rtl/tinyalu_cmd_sequencer_if.sv
// tinyalu_cmd_sequencer_if: command, ALU and response signals of the tiny ALU command sequencer
interface tinyalu_cmd_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_op;
    logic             alu_start;
    logic             alu_done;
    logic [15:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic [CW-1:0]    cmd_count;
    logic             busy;
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_done, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_err,
               rsp_tag, cmd_count, busy
    );
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, alu_done, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_err,
               rsp_tag, cmd_count, busy
    );
endinterface

// File: rtl/tinyalu_cmd_sequencer.sv
// tinyalu_cmd_sequencer: FIFO-buffered command issue to the tiny ALU with fixed-latency capture
module tinyalu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic reset_n,
    tinyalu_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;
    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    cmd_t          r_cmd;
    cmd_t          w_head;
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    state_t        r_state, w_next;
    logic [1:0]    r_lat;
    logic [1:0]    w_lat_exp;
    logic [15:0]   r_res;
    logic          r_err;
    logic          w_push, w_pop, w_cap, w_act;

    assign w_head    = r_mem[r_rp];
    assign w_push    = bus.cmd_valid && bus.cmd_ready;
    assign w_pop     = r_state == IDLE && r_cnt != '0;
    assign w_lat_exp = r_cmd.op == 3'd4 ? 2'd3 : 2'd1;
    assign w_cap     = r_state == WAIT && r_lat == w_lat_exp;
    assign w_act     = r_state == ISSUE || r_state == WAIT || r_state == DRAIN;

    assign bus.cmd_ready  = r_cnt != (AW+1)'(DEPTH);
    assign bus.cmd_count  = r_cnt;
    assign bus.busy       = r_state != IDLE || r_cnt != '0;
    assign bus.alu_start  = r_state == ISSUE;
    assign bus.alu_a      = w_act ? r_cmd.a : 8'd0;
    assign bus.alu_b      = w_act ? r_cmd.b : 8'd0;
    assign bus.alu_op     = w_act ? r_cmd.op : 3'd0;
    assign bus.rsp_valid  = r_state == RESP;
    assign bus.rsp_result = r_res;
    assign bus.rsp_err    = r_err;
    assign bus.rsp_tag    = r_cmd.tag;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_pop ? IDLE : (w_head.op inside {[3'd1:3'd4]}) ? ISSUE : RESP;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = !w_cap ? WAIT : r_lat == 2'd3 ? RESP : DRAIN;
            DRAIN:   w_next = r_lat == 2'd3 ? RESP : DRAIN;
            RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // storage needs no reset: occupancy is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= '{bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_lat   <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_rp  <= r_rp + 1'b1;
                r_cmd <= w_head;
                r_res <= '0;
                r_err <= w_head.op > 3'd4;
            end
            // r_lat counts cycles since the start pulse; DRAIN runs it out to 3
            if (r_state == ISSUE) r_lat <= 2'd1;
            else if (r_state == WAIT || r_state == DRAIN) r_lat <= r_lat + 2'd1;
            if (w_cap) begin
                r_res <= bus.alu_result;
                r_err <= !bus.alu_done;
            end
        end
    end
endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// tb_tinyalu_cmd_sequencer: directed stimulus, ALU model and scoreboard for the command sequencer
module tb_tinyalu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [15:0]      res;
        logic             err;
        logic [TAG_W-1:0] tag;
        bit               lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tinyalu_cmd_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus();
    tinyalu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    exp_t q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, t_start = 0, starts = 0, exp_starts = 0;
    int mode = 0;
    logic [1:0] age;
    logic [1:0] lm;
    logic prev_v = 1'b0;

    // ALU model: mode 0 done at T+L, mode 1 adds an early done at T+1, mode 2 never signals done
    function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n) age <= 2'd0;
        else age <= bus.alu_start ? 2'd1 : (age != 2'd0 && age != 2'd3) ? age + 2'd1 : 2'd0;

    assign lm             = bus.alu_op == 3'd4 ? 2'd3 : 2'd1;
    assign bus.alu_done   = (age == lm && mode != 2) || (mode == 1 && age == 2'd1);
    assign bus.alu_result = age == lm ? alu_f(bus.alu_a, bus.alu_b, bus.alu_op) : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            exp_t e;
            if (bus.alu_start) begin
                starts++;
                t_start = cyc;
            end
            if (bus.rsp_valid && !prev_v && q.size() > 0 && q[0].lat)
                chk("start_to_rsp_latency", cyc - t_start, 4);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got tag %0h result %0h with none expected",
                             bus.rsp_tag, bus.rsp_result);
                end else begin
                    e = q.pop_front();
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("rsp_tag", bus.rsp_tag, e.tag);
                end
            end
            prev_v = bus.rsp_valid;
        end else prev_v = 1'b0;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [TAG_W-1:0] tag, input logic [15:0] res, input logic err,
                        input bit expect_rsp, input int tmo, output bit ok);
        exp_t e;
        @(negedge clk);
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < tmo && !ok; i++) begin
            if (bus.cmd_ready) begin
                ok = 1'b1;
                e = '{res, err, tag, op inside {[3'd1:3'd4]}};
                if (expect_rsp) q.push_back(e);
                if (op inside {[3'd1:3'd4]}) exp_starts++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !bus.busy && !bus.rsp_valid) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d responses outstanding expected 0", nm, q.size());
        q.delete();
    endtask

    initial begin
        bit ok;
        int n_ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        bus.cmd_tag = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_cmd_count", bus.cmd_count, 0);
        chk("reset_alu_start", bus.alu_start, 0);
        reset_n = 1'b1;

        push(8'd3, 8'd5, 3'd1, 4'd2, 16'd8, 1'b0, 1'b1, 10, ok);
        wait_done("add");
        chk("add_start_count", starts, exp_starts);

        mode = 1;
        push(8'd255, 8'd255, 3'd4, 4'd3, 16'hFE01, 1'b0, 1'b1, 10, ok);
        wait_done("mul");
        mode = 0;

        push(8'd7, 8'd9, 3'd0, 4'd4, 16'd0, 1'b0, 1'b1, 10, ok);
        push(8'd7, 8'd9, 3'd6, 4'd5, 16'd0, 1'b1, 1'b1, 10, ok);
        wait_done("nop_illegal");
        chk("nop_illegal_no_start", starts, exp_starts);

        bus.rsp_ready = 1'b0;
        n_ok = 0;
        push(8'd10, 8'd20, 3'd1, 4'd6, 16'h001E, 1'b0, 1'b1, 10, ok); n_ok += int'(ok);
        push(8'hF0, 8'h3C, 3'd2, 4'd7, 16'h0030, 1'b0, 1'b1, 10, ok); n_ok += int'(ok);
        push(8'hAA, 8'h0F, 3'd3, 4'd8, 16'h00A5, 1'b0, 1'b1, 10, ok); n_ok += int'(ok);
        push(8'd12, 8'd11, 3'd4, 4'd9, 16'h0084, 1'b0, 1'b1, 10, ok); n_ok += int'(ok);
        push(8'd1, 8'd2, 3'd0, 4'd10, 16'h0000, 1'b0, 1'b1, 10, ok); n_ok += int'(ok);
        chk("full_accepted", n_ok, DEPTH + 1);
        chk("full_cmd_count", bus.cmd_count, DEPTH);
        chk("full_cmd_ready", bus.cmd_ready, 0);
        push(8'd1, 8'd1, 3'd1, 4'd11, 16'h0002, 1'b0, 1'b1, 4, ok);
        chk("full_extra_rejected", ok, 0);
        bus.rsp_ready = 1'b1;
        wait_done("full");
        chk("full_start_count", starts, exp_starts);

        mode = 2;
        push(8'h55, 8'h0F, 3'd3, 4'd12, 16'h005A, 1'b1, 1'b1, 10, ok);
        wait_done("missing_done");
        mode = 0;
        push(8'd100, 8'd200, 3'd1, 4'd13, 16'h012C, 1'b0, 1'b1, 10, ok);
        wait_done("after_missing_done");
        chk("missing_done_start_count", starts, exp_starts);

        push(8'd255, 8'd2, 3'd4, 4'd14, 16'h01FE, 1'b0, 1'b0, 10, ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.alu_start) ok = 1'b1;
            else @(negedge clk);
        end
        chk("reset_test_issue_seen", ok, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", bus.rsp_valid, 0);
        chk("midreset_alu_start", bus.alu_start, 0);
        chk("midreset_alu_a", bus.alu_a, 0);
        chk("midreset_alu_op", bus.alu_op, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_cmd_count", bus.cmd_count, 0);
        chk("midreset_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_cmd_count", bus.cmd_count, 0);
        chk("post_reset_rsp_valid", bus.rsp_valid, 0);
        chk("post_reset_start_count", starts, exp_starts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion within 20000 cycles");
        $fatal(1);
    end
endmodule
